// File: rtl/rx_pkg.sv
// Shared types for the receive frame-commit buffer: FSM states, stored entry, widths.
// Latency: none (types and a pure alignment helper only).
// Backpressure: not applicable.
package rx_pkg;

  localparam int WORD_W          = 32;
  localparam int DIBITS_PER_WORD = 16;
  localparam int DCNT_W          = $clog2(DIBITS_PER_WORD);
  localparam int ENTRY_W         = WORD_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    FLUSH,
    VERDICT,
    DROP
  } rx_commit_state_t;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } rx_entry_t;

  // Left-align a partially filled pack register holding cnt dibits.
  function automatic logic [WORD_W-1:0] align_partial(input logic [WORD_W-1:0] pack,
                                                      input logic [DCNT_W-1:0] cnt);
    return pack << (2 * (DIBITS_PER_WORD - int'(cnt)));
  endfunction

endpackage

// File: rtl/rx_word_ram.sv
// Simple dual-port word RAM (one write port, one read port) for the frame buffer.
// Latency: registered read, data valid one cycle after re.
// Backpressure: none; the caller guarantees write and read addresses never collide.
module rx_word_ram
  import rx_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int W     = ENTRY_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Synchronous read port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rx_frame_commit.sv
// Packs the firewall dibit stream into words, stores frames speculatively and commits/rewinds on verdict.
// Latency: done in cycle N gives first axiov in cycle N+3 (pointer update, RAM read, skid load).
// Backpressure: 2-entry output skid, axiod/axiol hold while axiov && !axior; optional stats via RX_FRAME_COMMIT_STATS_EN.
module rx_frame_commit
  import rx_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [1:0]        axiid,
  input  logic              done,
  input  logic              kill,
  input  logic              axior,
  output logic              axiov,
  output logic [WORD_W-1:0] axiod,
  output logic              axiol,
  output logic              overflow
`ifdef RX_FRAME_COMMIT_STATS_EN
  ,
  output logic [15:0]       frames_ok,
  output logic [15:0]       frames_bad,
  output logic [15:0]       frames_ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Write-side state.
  rx_commit_state_t  state, state_nxt;
  logic [WORD_W-1:0] pack, pack_nxt;
  logic [DCNT_W-1:0] cnt, cnt_nxt;
  logic [PW-1:0]     wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]     cm_ptr, cm_ptr_nxt;
  logic [WORD_W-1:0] last_word, last_word_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic              ovf_evt;
  logic              timer_hit;

  // RAM ports.
  logic              we;
  logic [AW-1:0]     waddr;
  rx_entry_t         wdata;
  rx_entry_t         ram_q;
  logic              rd_en;

  // Read side.
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     used;
  logic [PW-1:0]     wr_ptr_m1;
  logic              full;
  logic              rd_vld;
  logic [1:0]        skid_cnt;
  logic [1:0]        occ;
  logic              pop;
  rx_entry_t         e0, e1;

  // Space is measured against the read pointer: words already fetched into the skid are free.
  assign used      = wr_ptr - rd_ptr;
  assign full      = used[AW];
  assign wr_ptr_m1 = wr_ptr - PW'(1);
  assign timer_hit = (timer == TW'(TIMEOUT - 1));

  // Next-state, pack/counter and RAM write decode for the commit FSM.
  always_comb begin
    state_nxt     = state;
    pack_nxt      = pack;
    cnt_nxt       = cnt;
    wr_ptr_nxt    = wr_ptr;
    cm_ptr_nxt    = cm_ptr;
    last_word_nxt = last_word;
    timer_nxt     = timer;
    ovf_evt       = 1'b0;
    we            = 1'b0;
    waddr         = wr_ptr[AW-1:0];
    wdata         = '0;
    case (state)
      IDLE: begin
        if (axiiv) begin
          pack_nxt  = {pack[WORD_W-3:0], axiid};
          cnt_nxt   = DCNT_W'(1);
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (axiiv) begin
          pack_nxt = {pack[WORD_W-3:0], axiid};
          if (cnt == DCNT_W'(DIBITS_PER_WORD - 1)) begin
            if (full) begin
              ovf_evt    = 1'b1;
              wr_ptr_nxt = cm_ptr;
              state_nxt  = DROP;
            end else begin
              we            = 1'b1;
              wdata.last    = 1'b0;
              wdata.data    = pack_nxt;
              wr_ptr_nxt    = wr_ptr + PW'(1);
              last_word_nxt = pack_nxt;
              cnt_nxt       = '0;
            end
          end else begin
            cnt_nxt = cnt + DCNT_W'(1);
          end
        end else begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        timer_nxt = '0;
        if (cnt != '0) begin
          if (full) begin
            ovf_evt    = 1'b1;
            wr_ptr_nxt = cm_ptr;
            state_nxt  = DROP;
          end else begin
            we         = 1'b1;
            wdata.last = 1'b1;
            wdata.data = align_partial(pack, cnt);
            wr_ptr_nxt = wr_ptr + PW'(1);
            state_nxt  = VERDICT;
          end
        end else begin
          // Frame ended on a word boundary: re-mark the last full word as end of frame.
          we         = 1'b1;
          waddr      = wr_ptr_m1[AW-1:0];
          wdata.last = 1'b1;
          wdata.data = last_word;
          state_nxt  = VERDICT;
        end
      end
      VERDICT: begin
        if (kill) begin
          wr_ptr_nxt = cm_ptr;
          state_nxt  = IDLE;
        end else if (done) begin
          cm_ptr_nxt = wr_ptr;
          state_nxt  = IDLE;
        end else if (timer_hit) begin
          wr_ptr_nxt = cm_ptr;
          state_nxt  = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      DROP: begin
        if (!axiiv) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Commit FSM state register; reset discards every buffered and pending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pack      <= '0;
      cnt       <= '0;
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      last_word <= '0;
      timer     <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pack      <= pack_nxt;
      cnt       <= cnt_nxt;
      wr_ptr    <= wr_ptr_nxt;
      cm_ptr    <= cm_ptr_nxt;
      last_word <= last_word_nxt;
      timer     <= timer_nxt;
      overflow  <= ovf_evt;
    end
  end

  rx_word_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );

  // Reads stop at cm_ptr and only issue when the skid can absorb the returning word.
  assign pop   = axiov && axior;
  assign occ   = skid_cnt + {1'b0, rd_vld};
  assign rd_en = (rd_ptr != cm_ptr) && ((occ < 2'd2) || pop);

  // Read pointer, RAM-read valid pipe and 2-entry output skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      rd_vld   <= 1'b0;
      skid_cnt <= '0;
      e0       <= '0;
      e1       <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({rd_vld, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) begin
            e0 <= ram_q;
          end else begin
            e1 <= ram_q;
          end
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          e0       <= e1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            e0 <= ram_q;
          end else begin
            e0 <= e1;
            e1 <= ram_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign axiov = (skid_cnt != 2'd0);
  assign axiod = e0.data;
  assign axiol = e0.last;

`ifdef RX_FRAME_COMMIT_STATS_EN
  logic ok_evt;
  logic bad_evt;

  assign ok_evt  = (state == VERDICT) && done && !kill;
  assign bad_evt = (state == VERDICT) && (kill || (!done && timer_hit));

  // Saturating frame counters: commits, kills/timeouts, overflow drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_ok  <= '0;
      frames_bad <= '0;
      frames_ovf <= '0;
    end else begin
      if (ok_evt && (frames_ok != 16'hFFFF)) begin
        frames_ok <= frames_ok + 16'd1;
      end
      if (bad_evt && (frames_bad != 16'hFFFF)) begin
        frames_bad <= frames_bad + 16'd1;
      end
      if (overflow && (frames_ovf != 16'hFFFF)) begin
        frames_ovf <= frames_ovf + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_frame_commit.sv
// Directed bench for rx_frame_commit: default-depth instance plus a DEPTH=8 instance for overflow.
// Latency: drives inputs 1ns after posedge, samples outputs on negedge.
// Backpressure: exercises fixed and randomly toggled axior.
module tb_rx_frame_commit;

  logic        clk = 1'b0;
  logic        rst, rst8;
  logic        axiiv, done, kill, axior, axior8;
  logic [1:0]  axiid;
  logic        axiov, axiol, overflow;
  logic [31:0] axiod;
  logic        axiov8, axiol8, overflow8;
  logic [31:0] axiod8;
`ifdef RX_FRAME_COMMIT_STATS_EN
  logic [15:0] frames_ok, frames_bad, frames_ovf;
  logic [15:0] frames_ok8, frames_bad8, frames_ovf8;
`endif

  int checks   = 0;
  int failures = 0;
  bit rnd_rdy  = 1'b0;

  logic [31:0] fw [0:9];

  logic [31:0] got_d [$];
  logic        got_l [$];
  logic [31:0] g8_d [$];
  logic        g8_l [$];
  int          stab_err   = 0;
  logic        hold_chk   = 1'b0;
  logic [31:0] hold_d     = '0;
  logic        hold_l     = 1'b0;
  int          ovf_pulses = 0;
  int          ovf_cycles = 0;
  logic        ovf_prev   = 1'b0;

  always #5 clk = ~clk;

  rx_frame_commit dut (
    .clk      (clk),
    .rst      (rst),
    .axiiv    (axiiv),
    .axiid    (axiid),
    .done     (done),
    .kill     (kill),
    .axior    (axior),
    .axiov    (axiov),
    .axiod    (axiod),
    .axiol    (axiol),
    .overflow (overflow)
`ifdef RX_FRAME_COMMIT_STATS_EN
    ,
    .frames_ok  (frames_ok),
    .frames_bad (frames_bad),
    .frames_ovf (frames_ovf)
`endif
  );

  rx_frame_commit #(.DEPTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst8),
    .axiiv    (axiiv),
    .axiid    (axiid),
    .done     (done),
    .kill     (kill),
    .axior    (axior8),
    .axiov    (axiov8),
    .axiod    (axiod8),
    .axiol    (axiol8),
    .overflow (overflow8)
`ifdef RX_FRAME_COMMIT_STATS_EN
    ,
    .frames_ok  (frames_ok8),
    .frames_bad (frames_bad8),
    .frames_ovf (frames_ovf8)
`endif
  );

  // Output monitor: records transfers, counts hold-stability violations and overflow pulses.
  always @(negedge clk) begin
    if (hold_chk && (axiov !== 1'b1 || axiod !== hold_d || axiol !== hold_l)) begin
      stab_err++;
    end
    hold_chk = !rst && axiov && !axior;
    hold_d   = axiod;
    hold_l   = axiol;
    if (!rst && axiov && axior) begin
      got_d.push_back(axiod);
      got_l.push_back(axiol);
    end
    if (!rst8 && axiov8 && axior8) begin
      g8_d.push_back(axiod8);
      g8_l.push_back(axiol8);
    end
    if (!rst8 && overflow8) ovf_cycles++;
    if (!rst8 && overflow8 && !ovf_prev) ovf_pulses++;
    ovf_prev = overflow8;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) axior = ($urandom_range(0, 1) != 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send_frame(input int nd);
    logic [31:0] cur;
    for (int i = 0; i < nd; i++) begin
      tick();
      cur   = fw[i / 16];
      axiiv = 1'b1;
      axiid = cur[31 - 2 * (i % 16) -: 2];
    end
    tick();
    axiiv = 1'b0;
    axiid = 2'b00;
  endtask

  task automatic verdict(input logic d, input logic k);
    tick();
    done = d;
    kill = k;
    tick();
    done = 1'b0;
    kill = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    checks++; if (axiov !== 1'b0) begin failures++; $display("FAIL reset_axiov: got %b expected 0", axiov); end
    checks++; if (axiod !== 32'h0) begin failures++; $display("FAIL reset_axiod: got %h expected 00000000", axiod); end
    checks++; if (axiol !== 1'b0) begin failures++; $display("FAIL reset_axiol: got %b expected 0", axiol); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (overflow8 !== 1'b0) begin failures++; $display("FAIL reset_overflow8: got %b expected 0", overflow8); end
    tick();
    rst = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    checks++; if (axiov !== 1'b0) begin failures++; $display("FAIL idle_axiov: got %b expected 0", axiov); end
  endtask

  task automatic test_good_frame();
    int          base, lat;
    logic [31:0] exp_w [4];
    logic        exp_l [4];
    logic [31:0] od;
    logic        ol;
    exp_w = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    axior = 1'b1;
    base  = got_d.size();
    for (int i = 0; i < 4; i++) fw[i] = exp_w[i];
    send_frame(64);
    wait_cycles(4);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (axiov && lat == 0) lat = c;
    end
    checks++; if (lat !== 3) begin failures++; $display("FAIL good_latency: got %0d cycles expected 3", lat); end
    checks++; if (got_d.size() - base !== 4) begin failures++; $display("FAIL good_count: got %0d words expected 4", got_d.size() - base); end
    for (int i = 0; i < 4; i++) begin
      od = (base + i < got_d.size()) ? got_d[base + i] : 32'hBADBAD00;
      ol = (base + i < got_l.size()) ? got_l[base + i] : ~exp_l[i];
      checks++; if (od !== exp_w[i]) begin failures++; $display("FAIL good_word%0d: got %h expected %h", i, od, exp_w[i]); end
      checks++; if (ol !== exp_l[i]) begin failures++; $display("FAIL good_last%0d: got %b expected %b", i, ol, exp_l[i]); end
    end
  endtask

  task automatic test_kill();
    int          base;
    logic [31:0] exp_w [2];
    logic        exp_l [2];
    logic [31:0] od;
    logic        ol;
    exp_w = '{32'h55555555, 32'h50000000};
    exp_l = '{1'b0, 1'b1};
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    axior = 1'b1;
    base  = got_d.size();
    fw[0] = 32'h55555555;
    fw[1] = 32'h55555555;
    send_frame(20);
    wait_cycles(3);
    verdict(1'b0, 1'b1);
    wait_cycles(20);
    checks++; if (got_d.size() - base !== 0) begin failures++; $display("FAIL kill_no_output: got %0d words expected 0", got_d.size() - base); end
    checks++; if (dut.wr_ptr !== 10'd0) begin failures++; $display("FAIL kill_rewind: got wr_ptr %0d expected 0", dut.wr_ptr); end
    send_frame(18);
    wait_cycles(3);
    verdict(1'b1, 1'b0);
    wait_cycles(20);
    checks++; if (got_d.size() - base !== 2) begin failures++; $display("FAIL kill_next_count: got %0d words expected 2", got_d.size() - base); end
    for (int i = 0; i < 2; i++) begin
      od = (base + i < got_d.size()) ? got_d[base + i] : 32'hBADBAD00;
      ol = (base + i < got_l.size()) ? got_l[base + i] : ~exp_l[i];
      checks++; if (od !== exp_w[i]) begin failures++; $display("FAIL kill_next_word%0d: got %h expected %h", i, od, exp_w[i]); end
      checks++; if (ol !== exp_l[i]) begin failures++; $display("FAIL kill_next_last%0d: got %b expected %b", i, ol, exp_l[i]); end
    end
  endtask

  task automatic test_done_and_kill();
    int base;
    base  = got_d.size();
    fw[0] = 32'h55555555;
    fw[1] = 32'h55555555;
    send_frame(20);
    wait_cycles(3);
    verdict(1'b1, 1'b1);
    wait_cycles(20);
    checks++; if (got_d.size() - base !== 0) begin failures++; $display("FAIL both_no_output: got %0d words expected 0", got_d.size() - base); end
    checks++; if (dut.wr_ptr !== 10'd2) begin failures++; $display("FAIL both_rewind: got wr_ptr %0d expected 2", dut.wr_ptr); end
  endtask

  task automatic test_timeout();
    int          base;
    logic [31:0] exp_w [2];
    logic        exp_l [2];
    logic [31:0] od;
    logic        ol;
    exp_w = '{32'h55555555, 32'h55000000};
    exp_l = '{1'b0, 1'b1};
    base  = got_d.size();
    fw[0] = 32'h55555555;
    fw[1] = 32'h55555555;
    send_frame(20);
    wait_cycles(50);
    verdict(1'b1, 1'b0);
    wait_cycles(20);
    checks++; if (got_d.size() - base !== 2) begin failures++; $display("FAIL late_done_count: got %0d words expected 2", got_d.size() - base); end
    for (int i = 0; i < 2; i++) begin
      od = (base + i < got_d.size()) ? got_d[base + i] : 32'hBADBAD00;
      ol = (base + i < got_l.size()) ? got_l[base + i] : ~exp_l[i];
      checks++; if (od !== exp_w[i]) begin failures++; $display("FAIL late_done_word%0d: got %h expected %h", i, od, exp_w[i]); end
      checks++; if (ol !== exp_l[i]) begin failures++; $display("FAIL late_done_last%0d: got %b expected %b", i, ol, exp_l[i]); end
    end
    base = got_d.size();
    send_frame(20);
    wait_cycles(80);
    verdict(1'b1, 1'b0);
    wait_cycles(20);
    checks++; if (got_d.size() - base !== 0) begin failures++; $display("FAIL timeout_no_output: got %0d words expected 0", got_d.size() - base); end
    checks++; if (dut.wr_ptr !== 10'd4) begin failures++; $display("FAIL timeout_rewind: got wr_ptr %0d expected 4", dut.wr_ptr); end
`ifdef RX_FRAME_COMMIT_STATS_EN
    checks++; if (frames_bad !== 16'd3) begin failures++; $display("FAIL stats_bad: got %0d expected 3", frames_bad); end
    checks++; if (frames_ok !== 16'd2) begin failures++; $display("FAIL stats_ok: got %0d expected 2", frames_ok); end
`endif
  endtask

  task automatic test_back_to_back();
    int          base;
    logic [31:0] exp_w [7];
    logic        exp_l [7];
    logic [31:0] od;
    logic        ol;
    exp_w = '{32'h11223344, 32'h55667788, 32'h9ABC0000, 32'hCAFEF00D,
              32'h12345678, 32'hA5A5A5A5, 32'hC0000000};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    base    = got_d.size();
    rnd_rdy = 1'b1;
    fw[0] = 32'h11223344; fw[1] = 32'h55667788; fw[2] = 32'h9ABCDEF0;
    send_frame(40);
    wait_cycles(3);
    verdict(1'b1, 1'b0);
    fw[0] = 32'hCAFEF00D; fw[1] = 32'h12345678;
    send_frame(32);
    wait_cycles(3);
    verdict(1'b1, 1'b0);
    fw[0] = 32'hA5A5A5A5; fw[1] = 32'hFFFFFFFF;
    send_frame(17);
    wait_cycles(3);
    verdict(1'b1, 1'b0);
    wait_cycles(10);
    rnd_rdy = 1'b0;
    axior   = 1'b1;
    wait_cycles(40);
    checks++; if (got_d.size() - base !== 7) begin failures++; $display("FAIL b2b_count: got %0d words expected 7", got_d.size() - base); end
    for (int i = 0; i < 7; i++) begin
      od = (base + i < got_d.size()) ? got_d[base + i] : 32'hBADBAD00;
      ol = (base + i < got_l.size()) ? got_l[base + i] : ~exp_l[i];
      checks++; if (od !== exp_w[i]) begin failures++; $display("FAIL b2b_word%0d: got %h expected %h", i, od, exp_w[i]); end
      checks++; if (ol !== exp_l[i]) begin failures++; $display("FAIL b2b_last%0d: got %b expected %b", i, ol, exp_l[i]); end
    end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL hold_stable: got %0d violations expected 0", stab_err); end
  endtask

  task automatic test_overflow();
    int          base;
    logic [31:0] exp_w [4];
    logic        exp_l [4];
    logic [31:0] od;
    logic        ol;
    exp_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    rst    = 1'b1;
    axior8 = 1'b0;
    tick();
    rst8 = 1'b0;
    base = g8_d.size();
    for (int i = 0; i < 4; i++) fw[i] = exp_w[i];
    send_frame(64);
    wait_cycles(3);
    verdict(1'b1, 1'b0);
    wait_cycles(5);
    for (int i = 0; i < 10; i++) fw[i] = 32'h600D0000 + i;
    send_frame(160);
    wait_cycles(5);
    checks++; if (ovf_pulses !== 1) begin failures++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_pulses); end
    checks++; if (ovf_cycles !== 1) begin failures++; $display("FAIL ovf_width: got %0d cycles expected 1", ovf_cycles); end
    checks++; if (dut8.wr_ptr !== 4'd4) begin failures++; $display("FAIL ovf_rewind: got wr_ptr %0d expected 4", dut8.wr_ptr); end
`ifdef RX_FRAME_COMMIT_STATS_EN
    checks++; if (frames_ovf8 !== 16'd1) begin failures++; $display("FAIL stats_ovf: got %0d expected 1", frames_ovf8); end
`endif
    axior8 = 1'b1;
    wait_cycles(20);
    checks++; if (g8_d.size() - base !== 4) begin failures++; $display("FAIL ovf_drain_count: got %0d words expected 4", g8_d.size() - base); end
    for (int i = 0; i < 4; i++) begin
      od = (base + i < g8_d.size()) ? g8_d[base + i] : 32'hBADBAD00;
      ol = (base + i < g8_l.size()) ? g8_l[base + i] : ~exp_l[i];
      checks++; if (od !== exp_w[i]) begin failures++; $display("FAIL ovf_word%0d: got %h expected %h", i, od, exp_w[i]); end
      checks++; if (ol !== exp_l[i]) begin failures++; $display("FAIL ovf_last%0d: got %b expected %b", i, ol, exp_l[i]); end
    end
  endtask

  initial begin
    rst    = 1'b1;
    rst8   = 1'b1;
    axiiv  = 1'b0;
    axiid  = 2'b00;
    done   = 1'b0;
    kill   = 1'b0;
    axior  = 1'b1;
    axior8 = 1'b0;
    for (int i = 0; i < 10; i++) fw[i] = '0;
    test_reset();
    test_good_frame();
    test_kill();
    test_done_and_kill();
    test_timeout();
    test_back_to_back();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
